instr_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory, the successor of the fixed 4096×19 combinational ROM. It sits between the PC/fetch stage and the decode stage. It adds a write (load) port for boot-time or debug programming, a registered fetch path with a stall handshake, and a sequential clear-on-reset walker. It also adds range checking for depths smaller than the address space.

---
 rtl/instr_mem_sync_pkg.sv | 24 ++
 rtl/instr_mem_sync_if.sv | 44 ++++
 rtl/instr_mem_sync_array.sv | 42 ++++
 rtl/instr_mem_sync.sv | 130 +++++++++++++
 tb/tb_instr_mem_sync.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_pkg
//  Description : Shared types and constants for the synchronous instruction
//                memory and the fetch/decode stages around it.
//                - imem_state_t : controller state (clear walk / run)
//                - c_ADDR_W     : default PC / instruction address width
//                - c_DATA_W     : default instruction word width
//                - c_NOP        : default instruction word used as "no data"
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_mem_pkg;

    localparam int unsigned c_ADDR_W = 12;
    localparam int unsigned c_DATA_W = 19;
    localparam int unsigned c_NOP    = 0;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_t;

endpackage : instr_mem_pkg
`default_nettype wire

// File: rtl/instr_mem_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_sync_if
//  Description : Load + fetch bus between the fetch stage (master) and the
//                instruction memory (slave).
//                Master drives : load_en, load_addr, load_data, fetch_req,
//                                fetch_addr, fetch_stall
//                Slave drives  : ready, instr, instr_addr, instr_valid,
//                                instr_fault
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_mem_sync_if
    import instr_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DATA_W = c_DATA_W
);

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_valid;
    logic              instr_fault;

    modport master (
        output load_en, load_addr, load_data,
        output fetch_req, fetch_addr, fetch_stall,
        input  ready, instr, instr_addr, instr_valid, instr_fault
    );

    modport slave (
        input  load_en, load_addr, load_data,
        input  fetch_req, fetch_addr, fetch_stall,
        output ready, instr, instr_addr, instr_valid, instr_fault
    );

endinterface : instr_mem_sync_if
`default_nettype wire

// File: rtl/instr_mem_sync_array.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_array
//  Description : DEPTH x DATA_W storage, one write port and one synchronous
//                read port. A read and write to the same address in the same
//                cycle returns the write data (write-first).
//                i_clk   : clock
//                i_we    : write enable     i_waddr / i_wdata : write port
//                i_re    : read enable      i_raddr           : read address
//                o_rdata : registered read data, holds when i_re is low
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_array #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic              i_clk,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [IDX_W-1:0]  i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : instr_mem_array
`default_nettype wire

// File: rtl/instr_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_sync
//  Description : Parametrised synchronous-read instruction memory with a
//                load port, a registered stall-holding fetch path, range
//                checking and an optional clear-to-NOP walk after reset.
//                clock : rising-edge clock
//                reset : synchronous, active-high
//                bus   : instr_mem_sync_if.slave (load / fetch / result)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_sync
    import instr_mem_pkg::*;
#(
    parameter int unsigned         ADDR_W         = c_ADDR_W,
    parameter int unsigned         DATA_W         = c_DATA_W,
    parameter int unsigned         DEPTH          = 4096,
    parameter logic [DATA_W-1:0]   NOP            = DATA_W'(c_NOP),
    parameter bit                  CLEAR_ON_RESET = 1'b1
) (
    input  wire logic        clock,
    input  wire logic        reset,
    instr_mem_sync_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  c_CLR_LAST = CNT_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   c_DEPTH    = (ADDR_W + 1)'(DEPTH);

    imem_state_t       r_state;
    logic [CNT_W-1:0]  r_clr_cnt;
    logic [ADDR_W-1:0] r_instr_addr;
    logic              r_valid;
    logic              r_fault;
    // Selects NOP on the instr output: set by reset and by out-of-range
    // fetches, so the NOP persists while instr holds between fetches.
    logic              r_nop_sel;

    logic              w_ready;
    logic              w_load_ok;
    logic              w_fetch_ok;
    logic              w_accept;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_ready    = (r_state == ST_RUN);
    assign w_load_ok  = ({1'b0, bus.load_addr}  < c_DEPTH);
    assign w_fetch_ok = ({1'b0, bus.fetch_addr} < c_DEPTH);
    assign w_accept   = w_ready && bus.fetch_req && !bus.fetch_stall && !reset;

    // Write mux: clear walker owns the port during ST_CLEAR.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.load_addr[IDX_W-1:0];
        w_wdata = bus.load_data;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_cnt[IDX_W-1:0];
                w_wdata = NOP;
            end else begin
                w_we    = bus.load_en && w_load_ok;
            end
        end
    end

    assign w_re = w_accept && w_fetch_ok;

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (bus.fetch_addr[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_cnt    <= '0;
            r_instr_addr <= '0;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_nop_sel    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == c_CLR_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                ST_RUN:  r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase

            if (!bus.fetch_stall) begin
                if (w_accept) begin
                    r_instr_addr <= bus.fetch_addr;
                    r_valid      <= 1'b1;
                    r_fault      <= !w_fetch_ok;
                    r_nop_sel    <= !w_fetch_ok;
                end else begin
                    r_valid      <= 1'b0;
                    r_fault      <= 1'b0;
                end
            end
        end
    end

    assign bus.ready       = w_ready;
    assign bus.instr       = r_nop_sel ? NOP : w_rdata;
    assign bus.instr_addr  = r_instr_addr;
    assign bus.instr_valid = r_valid;
    assign bus.instr_fault = r_fault;

endmodule : instr_mem_sync
`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_sync
//  Description : Directed self-checking bench for instr_mem_sync. Instance A
//                clears on reset (DEPTH=16); instance B keeps its contents
//                across reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_sync;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 19;
    localparam int unsigned DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    instr_mem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    instr_mem_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    instr_mem_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .NOP('0), .CLEAR_ON_RESET(1'b1)
    ) u_dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    instr_mem_sync #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .NOP('0), .CLEAR_ON_RESET(1'b0)
    ) u_dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_instr,
                           input logic [31:0] e_addr, input logic e_valid,
                           input logic e_fault);
        chk({tag, ".instr"}, 32'(ifa.instr), e_instr);
        chk({tag, ".addr"},  32'(ifa.instr_addr), e_addr);
        chk({tag, ".valid"}, 32'(ifa.instr_valid), 32'(e_valid));
        chk({tag, ".fault"}, 32'(ifa.instr_fault), 32'(e_fault));
    endtask

    task automatic fetch_a(input int addr);
        ifa.fetch_req  = 1'b1;
        ifa.fetch_addr = ADDR_W'(addr);
        tick();
        ifa.fetch_req  = 1'b0;
    endtask

    task automatic load_a(input int addr, input int data);
        ifa.load_en   = 1'b1;
        ifa.load_addr = ADDR_W'(addr);
        ifa.load_data = DATA_W'(data);
        tick();
        ifa.load_en   = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.load_en = 1'b0; ifa.load_addr = '0; ifa.load_data = '0;
        ifa.fetch_req = 1'b0; ifa.fetch_addr = '0; ifa.fetch_stall = 1'b0;
        ifb.load_en = 1'b0; ifb.load_addr = '0; ifb.load_data = '0;
        ifb.fetch_req = 1'b0; ifb.fetch_addr = '0; ifb.fetch_stall = 1'b0;

        // Reset edge = cycle 0 of the clear walk.
        tick();
        rst_a = 1'b0;
        chk("rst.ready", 32'(ifa.ready), 32'd0);
        chk_out("rst", 0, 0, 1'b0, 1'b0);

        // Loads and fetches during clear must be ignored.
        ifa.load_en = 1'b1; ifa.load_addr = 12'd3; ifa.load_data = 19'h1234;
        ifa.fetch_req = 1'b1; ifa.fetch_addr = 12'd3;
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("clr%0d.ready", c), 32'(ifa.ready), 32'd0);
            chk($sformatf("clr%0d.valid", c), 32'(ifa.instr_valid), 32'd0);
        end
        tick();
        ifa.load_en = 1'b0; ifa.fetch_req = 1'b0;
        chk("clr16.ready", 32'(ifa.ready), 32'd1);
        chk("clr16.valid", 32'(ifa.instr_valid), 32'd0);

        // Sweep: every word reads NOP, back-to-back.
        ifa.fetch_req = 1'b1;
        for (int a = 0; a < 16; a++) begin
            ifa.fetch_addr = ADDR_W'(a);
            tick();
            chk_out($sformatf("sweep%0d", a), 0, a, 1'b1, 1'b0);
        end
        ifa.fetch_req = 1'b0;
        tick();
        chk_out("idle0", 0, 15, 1'b0, 1'b0);

        // Loads then back-to-back fetches.
        load_a(0, 25);
        load_a(1, 23);
        load_a(15, 30);
        ifa.fetch_req = 1'b1;
        ifa.fetch_addr = 12'd0;  tick(); chk_out("b2b0", 25, 0, 1'b1, 1'b0);
        ifa.fetch_addr = 12'd1;  tick(); chk_out("b2b1", 23, 1, 1'b1, 1'b0);
        ifa.fetch_addr = 12'd15; tick(); chk_out("b2b2", 30, 15, 1'b1, 1'b0);
        ifa.fetch_req = 1'b0;
        tick();
        chk_out("idle1", 30, 15, 1'b0, 1'b0);

        // Write-first bypass.
        ifa.load_en = 1'b1; ifa.load_addr = 12'd5; ifa.load_data = 19'h7FFFF;
        ifa.fetch_req = 1'b1; ifa.fetch_addr = 12'd5;
        tick();
        ifa.load_en = 1'b0; ifa.fetch_req = 1'b0;
        chk_out("bypass", 32'h7FFFF, 5, 1'b1, 1'b0);
        fetch_a(5);
        chk_out("stored5", 32'h7FFFF, 5, 1'b1, 1'b0);

        // Stall holds outputs; loads still land during stall.
        fetch_a(1);
        chk_out("pre_stall", 23, 1, 1'b1, 1'b0);
        ifa.fetch_req = 1'b1; ifa.fetch_addr = 12'd0; ifa.fetch_stall = 1'b1;
        ifa.load_en = 1'b1; ifa.load_addr = 12'd7; ifa.load_data = 19'h11;
        for (int s = 0; s < 3; s++) begin
            tick();
            ifa.load_en = 1'b0;
            chk_out($sformatf("stall%0d", s), 23, 1, 1'b1, 1'b0);
        end
        ifa.fetch_stall = 1'b0;
        tick();
        ifa.fetch_req = 1'b0;
        chk_out("post_stall", 25, 0, 1'b1, 1'b0);
        fetch_a(7);
        chk_out("stall_load", 32'h11, 7, 1'b1, 1'b0);

        // Out-of-range fetch and load.
        fetch_a(100);
        chk_out("fault", 0, 100, 1'b1, 1'b1);
        tick();
        chk_out("fault_idle", 0, 100, 1'b0, 1'b0);
        load_a(100, 32'h55);
        fetch_a(4);
        chk_out("oor_load", 0, 4, 1'b1, 1'b0);

        // Reset mid-stream with a fetch in flight.
        fetch_a(15);
        chk_out("pre_rst", 30, 15, 1'b1, 1'b0);
        ifa.fetch_req = 1'b1; ifa.fetch_addr = 12'd1;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0; ifa.fetch_req = 1'b0;
        chk_out("mid_rst", 0, 0, 1'b0, 1'b0);
        chk("mid_rst.ready", 32'(ifa.ready), 32'd0);

        // Reset again at clear cycle 7: walk restarts from 0.
        for (int c = 1; c <= 7; c++) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c <= 15; c++) begin
            chk($sformatf("re_clr%0d.ready", c), 32'(ifa.ready), 32'd0);
            tick();
        end
        chk("re_clr16.ready", 32'(ifa.ready), 32'd1);
        fetch_a(0);
        chk_out("cleared0", 0, 0, 1'b1, 1'b0);
        fetch_a(15);
        chk_out("cleared15", 0, 15, 1'b1, 1'b0);

        // Instance B: no clear, contents persist across reset.
        rst_b = 1'b0;
        chk("b.rst.ready", 32'(ifb.ready), 32'd1);
        chk("b.rst.valid", 32'(ifb.instr_valid), 32'd0);
        ifb.load_en = 1'b1; ifb.load_addr = 12'd2; ifb.load_data = 19'h3ABCD;
        tick();
        ifb.load_en = 1'b0;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("b.after_rst.ready", 32'(ifb.ready), 32'd1);
        chk("b.after_rst.instr", 32'(ifb.instr), 32'd0);
        ifb.fetch_req = 1'b1; ifb.fetch_addr = 12'd2;
        tick();
        ifb.fetch_req = 1'b0;
        chk("b.persist.instr", 32'(ifb.instr), 32'h3ABCD);
        chk("b.persist.valid", 32'(ifb.instr_valid), 32'd1);
        chk("b.persist.addr", 32'(ifb.instr_addr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_instr_mem_sync
`default_nettype wire
